// File: rtl/mem_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_e;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_DWORD = 2'b11;

  localparam int DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input round-robin picker; the last-grant register flips priority on ties.
module rr_arb2
  import mem_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   req_i,
  input  logic   req_d,
  input  logic   accept,
  output logic   vld,
  output grant_e gnt
);

  grant_e last_q, last_d;

  always_comb begin
    vld = req_i | req_d;
    gnt = GNT_I;
    if (req_i && req_d) begin
      gnt = (last_q == GNT_D) ? GNT_I : GNT_D;
    end else if (req_d) begin
      gnt = GNT_D;
    end
    last_d = (accept && vld) ? gnt : last_q;
  end

  // Reset to D so the instruction port wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= GNT_D;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one shared RAM port,
// with round-robin fairness and a per-access ack timeout.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int PLEN    = 64,
  parameter int DLEN    = 64,
  parameter int ILEN    = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_req,
  input  logic [PLEN-1:0] i_addr,
  output logic [ILEN-1:0] i_rdata,
  output logic            i_ack,
  output logic            i_err,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [1:0]      d_len,
  input  logic [PLEN-1:0] d_addr,
  input  logic [DLEN-1:0] d_wdata,
  output logic [DLEN-1:0] d_rdata,
  output logic            d_ack,
  output logic            d_err,
  output logic [PLEN-1:0] ram_addr,
  output logic [DLEN-1:0] ram_wdata,
  output logic [1:0]      ram_len,
  output logic            ram_re,
  output logic            ram_we,
  input  logic [DLEN-1:0] ram_rdata,
  input  logic            ram_ack
);

  localparam logic [7:0] TO_C = 8'(TIMEOUT);

  arb_state_e      state_q, state_d;
  grant_e          gnt_q, gnt_d;
  logic [PLEN-1:0] addr_q, addr_d;
  logic [DLEN-1:0] wdata_q, wdata_d;
  logic [1:0]      len_q, len_d;
  logic            we_q, we_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [ILEN-1:0] i_rdata_q, i_rdata_d;
  logic [DLEN-1:0] d_rdata_q, d_rdata_d;
  logic [7:0]      cnt_inc;

  logic   arb_vld;
  logic   arb_accept;
  grant_e arb_gnt;

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_i  (i_req),
    .req_d  (d_req),
    .accept (arb_accept),
    .vld    (arb_vld),
    .gnt    (arb_gnt)
  );

  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    len_d      = len_q;
    we_d       = we_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    arb_accept = 1'b0;

    case (state_q)
      IDLE: begin
        if (arb_vld) begin
          arb_accept = 1'b1;
          gnt_d      = arb_gnt;
          cnt_d      = '0;
          err_d      = 1'b0;
          state_d    = BUSY;
          if (arb_gnt == GNT_I) begin
            addr_d  = i_addr;
            wdata_d = '0;
            len_d   = SZ_WORD;
            we_d    = 1'b0;
          end else begin
            addr_d  = d_addr;
            wdata_d = d_wdata;
            len_d   = d_len;
            we_d    = d_we;
          end
        end
      end
      BUSY: begin
        // An ack arriving on the final allowed cycle still counts as success.
        if (ram_ack) begin
          err_d   = 1'b0;
          state_d = DONE;
          if (gnt_q == GNT_I) i_rdata_d = ram_rdata[ILEN-1:0];
          else                d_rdata_d = ram_rdata;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TO_C) begin
            err_d   = 1'b1;
            state_d = DONE;
            if (gnt_q == GNT_I) i_rdata_d = '0;
            else                d_rdata_d = '0;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= GNT_I;
      addr_q    <= '0;
      wdata_q   <= '0;
      len_q     <= '0;
      we_q      <= 1'b0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      len_q     <= len_d;
      we_q      <= we_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Every RAM-side output decodes registers only, so strobes drop with the async reset.
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign ram_len   = len_q;
  assign ram_re    = (state_q == BUSY) && !we_q;
  assign ram_we    = (state_q == BUSY) &&  we_q;

  assign i_ack   = (state_q == DONE) && (gnt_q == GNT_I);
  assign d_ack   = (state_q == DONE) && (gnt_q == GNT_D);
  assign i_err   = i_ack && err_q;
  assign d_err   = d_ack && err_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with TIMEOUT=4 and hand-computed expectations.
module tb_mem_arbiter;

  localparam int PLEN = 64;
  localparam int DLEN = 64;
  localparam int ILEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            i_req;
  logic [PLEN-1:0] i_addr;
  logic [ILEN-1:0] i_rdata;
  logic            i_ack, i_err;
  logic            d_req, d_we;
  logic [1:0]      d_len;
  logic [PLEN-1:0] d_addr;
  logic [DLEN-1:0] d_wdata;
  logic [DLEN-1:0] d_rdata;
  logic            d_ack, d_err;
  logic [PLEN-1:0] ram_addr;
  logic [DLEN-1:0] ram_wdata;
  logic [1:0]      ram_len;
  logic            ram_re, ram_we;
  logic [DLEN-1:0] ram_rdata;
  logic            ram_ack;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.PLEN(PLEN), .DLEN(DLEN), .ILEN(ILEN), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_len(d_len), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_len(ram_len),
    .ram_re(ram_re), .ram_we(ram_we), .ram_rdata(ram_rdata), .ram_ack(ram_ack)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_len = '0;
    d_addr = '0; d_wdata = '0; ram_rdata = '0; ram_ack = 0;
    #2;
    n_checks++; if (ram_re !== 1'b0) begin n_fail++; $display("FAIL reset_ram_re: got %b expected 0", ram_re); end
    step(); step();
    n_checks++; if ({ram_re, ram_we, i_ack, d_ack, i_err, d_err} !== 6'b0) begin n_fail++; $display("FAIL reset_strobes: got %b expected 000000", {ram_re, ram_we, i_ack, d_ack, i_err, d_err}); end
    n_checks++; if (i_rdata !== '0 || d_rdata !== '0) begin n_fail++; $display("FAIL reset_rdata: got %h/%h expected 0/0", i_rdata, d_rdata); end
    n_checks++; if (ram_addr !== '0 || ram_len !== 2'b00) begin n_fail++; $display("FAIL reset_ram_addr: got %h/%b expected 0/00", ram_addr, ram_len); end
    rst_n = 1'b1;
  endtask

  task automatic test_fetch();
    i_req = 1; i_addr = 64'h1000;
    step();
    n_checks++; if (ram_re !== 1'b1 || ram_we !== 1'b0) begin n_fail++; $display("FAIL fetch_strobe: got re=%b we=%b expected re=1 we=0", ram_re, ram_we); end
    n_checks++; if (ram_addr !== 64'h1000 || ram_len !== 2'b10) begin n_fail++; $display("FAIL fetch_addr: got %h len %b expected 1000 len 10", ram_addr, ram_len); end
    ram_ack = 1; ram_rdata = 64'h00000000DEADBEEF;
    step();
    ram_ack = 0; i_req = 0;
    n_checks++; if (i_ack !== 1'b1 || i_err !== 1'b0 || d_ack !== 1'b0) begin n_fail++; $display("FAIL fetch_ack: got i_ack=%b i_err=%b d_ack=%b expected 1 0 0", i_ack, i_err, d_ack); end
    n_checks++; if (i_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL fetch_rdata: got %h expected deadbeef", i_rdata); end
    n_checks++; if (ram_re !== 1'b0) begin n_fail++; $display("FAIL fetch_done_re: got %b expected 0", ram_re); end
    step();
    n_checks++; if (i_ack !== 1'b0) begin n_fail++; $display("FAIL fetch_ack_pulse: got %b expected 0", i_ack); end
  endtask

  task automatic test_round_robin();
    logic [DLEN-1:0] rd;
    logic [ILEN-1:0] last_i;
    bit is_i;
    do_reset();
    i_req = 1; i_addr = 64'h1000;
    d_req = 1; d_we = 0; d_len = 2'b11; d_addr = 64'h3000; d_wdata = '0;
    last_i = 32'h0;
    for (int k = 0; k < 4; k++) begin
      is_i = (k % 2) == 0;
      rd = {32'hA0A0A0A0 + 32'(k), 32'h50000000 + 32'(k)};
      step();
      n_checks++; if (ram_addr !== (is_i ? 64'h1000 : 64'h3000)) begin n_fail++; $display("FAIL rr_grant_%0d: got addr %h expected %h", k, ram_addr, is_i ? 64'h1000 : 64'h3000); end
      ram_ack = 1; ram_rdata = rd;
      step();
      ram_ack = 0;
      n_checks++; if (i_ack !== is_i || d_ack !== !is_i) begin n_fail++; $display("FAIL rr_ack_%0d: got i_ack=%b d_ack=%b expected %b %b", k, i_ack, d_ack, is_i, !is_i); end
      if (is_i) begin
        n_checks++; if (i_rdata !== rd[31:0]) begin n_fail++; $display("FAIL rr_irdata_%0d: got %h expected %h", k, i_rdata, rd[31:0]); end
        last_i = rd[31:0];
      end else begin
        n_checks++; if (d_rdata !== rd || i_rdata !== last_i) begin n_fail++; $display("FAIL rr_drdata_%0d: got %h/%h expected %h/%h", k, d_rdata, i_rdata, rd, last_i); end
      end
      if (k == 3) begin i_req = 0; d_req = 0; end
      step();
    end
  endtask

  task automatic test_store();
    d_req = 1; d_we = 1; d_addr = 64'h2008; d_wdata = 64'h0123456789ABCDEF; d_len = 2'b11;
    step();
    n_checks++; if (ram_we !== 1'b1 || ram_re !== 1'b0) begin n_fail++; $display("FAIL store_strobe: got we=%b re=%b expected 1 0", ram_we, ram_re); end
    n_checks++; if (ram_addr !== 64'h2008 || ram_wdata !== 64'h0123456789ABCDEF || ram_len !== 2'b11) begin n_fail++; $display("FAIL store_payload: got %h %h %b expected 2008 0123456789abcdef 11", ram_addr, ram_wdata, ram_len); end
    d_addr = 64'hFFFF; d_wdata = 64'h5555;
    step();
    n_checks++; if (ram_addr !== 64'h2008 || ram_wdata !== 64'h0123456789ABCDEF) begin n_fail++; $display("FAIL store_hold: got %h %h expected 2008 0123456789abcdef", ram_addr, ram_wdata); end
    ram_ack = 1; ram_rdata = 64'hCAFEF00D11223344;
    step();
    ram_ack = 0; d_req = 0; d_we = 0;
    n_checks++; if (d_ack !== 1'b1 || d_err !== 1'b0 || i_ack !== 1'b0 || ram_we !== 1'b0) begin n_fail++; $display("FAIL store_ack: got d_ack=%b d_err=%b i_ack=%b we=%b expected 1 0 0 0", d_ack, d_err, i_ack, ram_we); end
    step();
    n_checks++; if (d_ack !== 1'b0) begin n_fail++; $display("FAIL store_ack_pulse: got %b expected 0", d_ack); end
  endtask

  task automatic test_timeout();
    d_req = 1; d_we = 0; d_addr = 64'h4000; d_len = 2'b11; ram_ack = 0;
    for (int c = 0; c < 4; c++) step();
    n_checks++; if (ram_re !== 1'b1 || d_ack !== 1'b0) begin n_fail++; $display("FAIL timeout_busy4: got re=%b d_ack=%b expected 1 0", ram_re, d_ack); end
    step();
    d_req = 0;
    n_checks++; if (d_ack !== 1'b1 || d_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got d_ack=%b d_err=%b expected 1 1", d_ack, d_err); end
    n_checks++; if (d_rdata !== '0 || ram_re !== 1'b0 || ram_we !== 1'b0) begin n_fail++; $display("FAIL timeout_done: got rdata=%h re=%b we=%b expected 0 0 0", d_rdata, ram_re, ram_we); end
    step();
    n_checks++; if (d_ack !== 1'b0 || d_err !== 1'b0) begin n_fail++; $display("FAIL timeout_clear: got %b %b expected 0 0", d_ack, d_err); end
  endtask

  task automatic test_ack_boundary();
    d_req = 1; d_we = 0; d_addr = 64'h4100; ram_ack = 0;
    for (int c = 0; c < 4; c++) step();
    ram_ack = 1; ram_rdata = 64'h0BADF00D12345678;
    step();
    d_req = 0;
    n_checks++; if (d_ack !== 1'b1 || d_err !== 1'b0) begin n_fail++; $display("FAIL boundary_ack: got d_ack=%b d_err=%b expected 1 0", d_ack, d_err); end
    n_checks++; if (d_rdata !== 64'h0BADF00D12345678) begin n_fail++; $display("FAIL boundary_rdata: got %h expected 0badf00d12345678", d_rdata); end
    ram_rdata = 64'h1;
    step();
    step();
    n_checks++; if (d_ack !== 1'b0 || i_ack !== 1'b0 || ram_re !== 1'b0 || d_rdata !== 64'h0BADF00D12345678) begin n_fail++; $display("FAIL idle_ack_ignored: got d_ack=%b i_ack=%b re=%b rdata=%h expected 0 0 0 0badf00d12345678", d_ack, i_ack, ram_re, d_rdata); end
    ram_ack = 0;
  endtask

  task automatic test_reset_mid_busy();
    i_req = 1; i_addr = 64'h5000;
    step();
    n_checks++; if (ram_re !== 1'b1) begin n_fail++; $display("FAIL midrst_busy: got %b expected 1", ram_re); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (ram_re !== 1'b0 || i_rdata !== '0) begin n_fail++; $display("FAIL midrst_async: got re=%b rdata=%h expected 0 0", ram_re, i_rdata); end
    step();
    n_checks++; if (i_ack !== 1'b0) begin n_fail++; $display("FAIL midrst_noack: got %b expected 0", i_ack); end
    rst_n = 1'b1;
    step();
    n_checks++; if (ram_re !== 1'b1 || ram_addr !== 64'h5000) begin n_fail++; $display("FAIL midrst_regrant: got re=%b addr=%h expected 1 5000", ram_re, ram_addr); end
    ram_ack = 1; ram_rdata = 64'hFFFFFFFF87654321;
    step();
    ram_ack = 0; i_req = 0;
    n_checks++; if (i_ack !== 1'b1 || i_err !== 1'b0 || i_rdata !== 32'h87654321) begin n_fail++; $display("FAIL midrst_after: got ack=%b err=%b rdata=%h expected 1 0 87654321", i_ack, i_err, i_rdata); end
    step();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_round_robin();
    test_store();
    test_timeout();
    test_ack_boundary();
    test_reset_mid_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter PLEN, default 64, physical address width.
REQ-002 Parameter DLEN, default 64, data width.
REQ-003 Parameter ILEN, default 32, instruction width.
REQ-004 Parameter TIMEOUT, default 15, max cycles to wait for ram_ack (range 1..255).
REQ-005 One clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 i_req / i_addr  in  1 / PLEN  instruction-fetch request and address.
REQ-009 i_rdata / i_ack / i_err  out  ILEN / 1 / 1  fetched word, completion pulse, timeout flag.
REQ-010 d_req / d_we / d_len / d_addr / d_wdata  in  1 / 1 / 2 / PLEN / DLEN  data request, write enable, size code, address, store data.
REQ-011 d_rdata / d_ack / d_err  out  DLEN / 1 / 1  load data, completion pulse, timeout flag.
REQ-012 ram_addr / ram_wdata / ram_len / ram_re / ram_we  out  PLEN / DLEN / 2 / 1 / 1  shared RAM port.
REQ-013 ram_rdata / ram_ack  in  DLEN / 1  RAM read data, access-complete strobe.

Function
REQ-014 FSM states IDLE, BUSY, DONE; grant register selects I or D.
REQ-015 IDLE: single request -> grant it; both -> grant the requester not granted last (round-robin); none -> stay IDLE.
REQ-016 On grant edge: latch addr, wdata, len, we (fetch: we=0, len=2'b10) and go BUSY.
REQ-017 BUSY: ram_addr/ram_wdata/ram_len driven from latches; ram_re = ~we_latched, ram_we = we_latched; all from registers.
REQ-018 BUSY with ram_ack=1: capture ram_rdata (fetch: ram_rdata[ILEN-1:0]) -> DONE.
REQ-019 Timeout counter cleared at grant, incremented each BUSY cycle without ram_ack; reaching TIMEOUT -> DONE with err set, captured data 0.
REQ-020 ram_ack in the same cycle the counter reaches TIMEOUT: ack wins, err=0.
REQ-021 DONE: lasts exactly one cycle; granted requester's ack=1 (err if timed out); ram_re=ram_we=0; then IDLE.
REQ-022 Minimum latency: req cycle 0, ram strobe cycle 1, ram_ack cycle 1 -> ack cycle 2; next grant earliest edge ending cycle 3.
REQ-023 Requester holds req and payload until its ack; payload changes mid-access are ignored.
REQ-024 Non-granted requester's ack/err remain 0; its request waits, never dropped.
REQ-025 rdata outputs hold last captured value until next capture for that requester.
REQ-026 ram_ack outside BUSY is ignored.

Reset
REQ-027 rst_n low: state IDLE, last-grant = D (instruction wins first tie), counter 0, all outputs 0, immediately and asynchronously.
REQ-028 Reset mid-access aborts it: no ack issued, RAM strobes drop without waiting for clk.
REQ-029 First grant possible on the first rising edge after rst_n deasserts.

Structure
REQ-030 Shared package mem_pkg holds arb_state_e (IDLE/BUSY/DONE), grant_e (GNT_I/GNT_D), size-code constants (byte/half/word/dword) and default TIMEOUT.
REQ-031 One sub-module natural: rr_arb2 (two-input round-robin picker with last-grant register); counter and FSM inline.
REQ-032 No combinational path from any input to any RAM-side output.

Verification
REQ-033 Fetch only: i_addr=0x1000, ram_ack one cycle after ram_re, ram_rdata=0x00000000DEADBEEF -> i_ack cycle 2, i_rdata=0xDEADBEEF, i_err=0.
REQ-034 Simultaneous after reset: i_req, d_req held -> I granted first, then D; repeat -> alternates I,D,I,D.
REQ-035 Store: d_we=1, d_addr=0x2008, d_wdata=0x0123456789ABCDEF, d_len=3 -> ram_we=1 with those values, ram_re=0, d_ack one pulse.
REQ-036 Timeout: TIMEOUT=4, no ram_ack -> d_err=d_ack=1 after 4 BUSY cycles, d_rdata=0, ram strobes low in DONE.
REQ-037 Ack at boundary: TIMEOUT=4, ram_ack on 4th BUSY cycle -> ack with err=0 and captured data.
REQ-038 Reset mid-BUSY: rst_n low one cycle -> ram_re falls asynchronously, no ack, next request served normally.
